// File: rtl/recon_dma_pkg.sv
// Shared definitions for the reconfiguration DMA read-channel arbiter:
// tag field widths, status codes, FSM encoding and tag pack/unpack helpers.
package recon_dma_pkg;

  localparam int unsigned SEQ_W_DEF = 4;
  localparam int unsigned TAG_W_DEF = 8;
  localparam int unsigned CNT_W     = 4;

  localparam logic [3:0] ERR_TIMEOUT = 4'hF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Tag layout is {zero pad, port index, sequence}; callers truncate to TAG_WIDTH.
  function automatic logic [31:0] tag_pack(input logic [31:0] port,
                                           input logic [31:0] seq,
                                           input int unsigned seq_w);
    logic [31:0] mask;
    mask = (32'd1 << seq_w) - 32'd1;
    return (port << seq_w) | (seq & mask);
  endfunction

  function automatic logic [31:0] tag_port(input logic [31:0] tag,
                                           input int unsigned seq_w,
                                           input int unsigned port_w);
    logic [31:0] mask;
    mask = (32'd1 << port_w) - 32'd1;
    return (tag >> seq_w) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester above last_grant, wrapping.
// Purely combinational; the caller owns the last_grant register.
module rr_arbiter #(
  parameter int unsigned PORTS = 4,
  localparam int unsigned PORT_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0]  req,
  input  logic [PORT_W-1:0] last_grant,
  output logic [PORTS-1:0]  grant,
  output logic              grant_valid,
  output logic [PORT_W-1:0] grant_idx
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand = PORT_W'((32'(last_grant) + i) % PORTS);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/recon_dma_rd_arbiter.sv
// Shares one DMA read-descriptor channel among PORTS requesters with
// tag-routed completion status. Optional watchdog: RECON_DMA_ARB_TIMEOUT_EN.
module recon_dma_rd_arbiter
  import recon_dma_pkg::*;
#(
  parameter int unsigned PORTS           = 4,
  parameter int unsigned ADDR_WIDTH      = 34,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned TAG_WIDTH       = 8,
  parameter int unsigned SEQ_W           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*ADDR_WIDTH-1:0] s_req_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]  s_req_len,
  input  logic [PORTS-1:0]            s_req_valid,
  output logic [PORTS-1:0]            s_req_ready,
  output logic [ADDR_WIDTH-1:0]       m_axis_read_desc_addr,
  output logic [LEN_WIDTH-1:0]        m_axis_read_desc_len,
  output logic [TAG_WIDTH-1:0]        m_axis_read_desc_tag,
  output logic                        m_axis_read_desc_valid,
  input  logic                        m_axis_read_desc_ready,
  input  logic [TAG_WIDTH-1:0]        s_axis_read_desc_status_tag,
  input  logic [3:0]                  s_axis_read_desc_status_error,
  input  logic                        s_axis_read_desc_status_valid,
  output logic [PORTS-1:0]            m_status_valid,
  output logic [3:0]                  m_status_error,
  output logic [SEQ_W-1:0]            m_status_seq,
  output logic [PORTS*4-1:0]          outstanding,
  output logic                        err_unexpected
`ifdef RECON_DMA_ARB_TIMEOUT_EN
  ,
  output logic [PORTS-1:0]            timeout_err
`endif
);

  localparam int unsigned PORT_W = $clog2(PORTS);

  logic [0:0]            state_q, state_d;
  logic [PORT_W-1:0]     last_grant_q, last_grant_d;
  logic [SEQ_W-1:0]      seq_q [PORTS];
  logic [SEQ_W-1:0]      seq_d [PORTS];
  logic [CNT_W-1:0]      out_q [PORTS];
  logic [CNT_W-1:0]      out_d [PORTS];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  valid_q, valid_d;
  logic [PORTS-1:0]      stv_q, stv_d;
  logic [3:0]            ste_q, ste_d;
  logic [SEQ_W-1:0]      sts_q, sts_d;
  logic                  unexp_q, unexp_d;

  logic [PORTS-1:0]      elig, arb_req, arb_grant;
  logic                  arb_valid;
  logic [PORT_W-1:0]     arb_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [SEQ_W-1:0]      sel_seq;
  logic [PORT_W-1:0]     st_port;
  logic [SEQ_W-1:0]      st_seq;
  logic [PORTS-1:0]      st_hit, st_dec;

  // Ports at their in-flight limit are masked out and never block others.
  always_comb begin
    elig = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      elig[p] = s_req_valid[p] && (out_q[p] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  assign arb_req = (state_q == ST_IDLE) ? elig : '0;

  rr_arbiter #(.PORTS(PORTS)) u_rr_arbiter (
    .req         (arb_req),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  assign s_req_ready = arb_grant;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_seq  = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (arb_grant[p]) begin
        sel_addr = s_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = s_req_len[p*LEN_WIDTH +: LEN_WIDTH];
        sel_seq  = seq_q[p];
      end
    end
  end

  // Status decode; a port index outside 0..PORTS-1 hits nothing and is unexpected.
  assign st_port = PORT_W'(tag_port(32'(s_axis_read_desc_status_tag), SEQ_W, PORT_W));
  assign st_seq  = SEQ_W'(s_axis_read_desc_status_tag);

  always_comb begin
    st_hit = '0;
    st_dec = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      st_hit[p] = s_axis_read_desc_status_valid && (32'(st_port) == p);
      st_dec[p] = st_hit[p] && (out_q[p] != '0);
    end
  end

`ifdef RECON_DMA_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]  wd_q [PORTS];
  logic [WD_W-1:0]  wd_d [PORTS];
  logic [PORTS-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    stv_d        = '0;
    ste_d        = '0;
    sts_d        = '0;
    unexp_d      = unexp_q | (s_axis_read_desc_status_valid && (st_dec == '0));
    for (int unsigned p = 0; p < PORTS; p++) begin
      seq_d[p] = seq_q[p];
      out_d[p] = out_q[p];
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          addr_d       = sel_addr;
          len_d        = sel_len;
          tag_d        = TAG_WIDTH'(tag_pack(32'(arb_idx), 32'(sel_seq), SEQ_W));
          valid_d      = 1'b1;
          last_grant_d = arb_idx;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axis_read_desc_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant and completion on the same port in one cycle cancel out.
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (arb_grant[p]) begin
        seq_d[p] = seq_q[p] + SEQ_W'(1);
      end
      if (arb_grant[p] && !st_dec[p]) begin
        out_d[p] = out_q[p] + CNT_W'(1);
      end else if (!arb_grant[p] && st_dec[p]) begin
        out_d[p] = out_q[p] - CNT_W'(1);
      end
    end

    if (st_dec != '0) begin
      stv_d = st_dec;
      ste_d = s_axis_read_desc_status_error;
      sts_d = st_seq;
    end

`ifdef RECON_DMA_ARB_TIMEOUT_EN
    to_d = to_q;
    for (int unsigned p = 0; p < PORTS; p++) begin
      wd_d[p] = wd_q[p];
      if (st_hit[p] || (out_q[p] == '0)) begin
        wd_d[p] = '0;
      end else if (wd_q[p] == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wd_d[p]  = '0;
        out_d[p] = arb_grant[p] ? CNT_W'(1) : '0;
        stv_d[p] = 1'b1;
        ste_d    = ERR_TIMEOUT;
        sts_d    = '0;
        to_d[p]  = 1'b1;
      end else begin
        wd_d[p] = wd_q[p] + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_W'(PORTS - 1);
      addr_q       <= '0;
      len_q        <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      stv_q        <= '0;
      ste_q        <= '0;
      sts_q        <= '0;
      unexp_q      <= 1'b0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        seq_q[p] <= '0;
        out_q[p] <= '0;
      end
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      stv_q        <= stv_d;
      ste_q        <= ste_d;
      sts_q        <= sts_d;
      unexp_q      <= unexp_d;
      for (int unsigned p = 0; p < PORTS; p++) begin
        seq_q[p] <= seq_d[p];
        out_q[p] <= out_d[p];
      end
    end
  end

`ifdef RECON_DMA_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        wd_q[p] <= '0;
      end
    end else begin
      to_q <= to_d;
      for (int unsigned p = 0; p < PORTS; p++) begin
        wd_q[p] <= wd_d[p];
      end
    end
  end

  assign timeout_err = to_q;
`endif

  assign m_axis_read_desc_addr  = addr_q;
  assign m_axis_read_desc_len   = len_q;
  assign m_axis_read_desc_tag   = tag_q;
  assign m_axis_read_desc_valid = valid_q;
  assign m_status_valid         = stv_q;
  assign m_status_error         = ste_q;
  assign m_status_seq           = sts_q;
  assign err_unexpected         = unexp_q;

  always_comb begin
    outstanding = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      outstanding[p*CNT_W +: CNT_W] = out_q[p];
    end
  end

endmodule

// File: tb/tb_recon_dma_rd_arbiter.sv
// Directed self-checking bench for recon_dma_rd_arbiter (default build,
// 4 ports, tag = {port[1:0], seq[3:0]}, two reads in flight per port).
module tb_recon_dma_rd_arbiter;

  localparam int PORTS = 4;
  localparam int AW    = 34;
  localparam int LW    = 20;
  localparam int TW    = 8;
  localparam int SW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PORTS*AW-1:0]   s_req_addr;
  logic [PORTS*LW-1:0]   s_req_len;
  logic [PORTS-1:0]      s_req_valid;
  logic [PORTS-1:0]      s_req_ready;
  logic [AW-1:0]         desc_addr;
  logic [LW-1:0]         desc_len;
  logic [TW-1:0]         desc_tag;
  logic                  desc_valid;
  logic                  desc_ready;
  logic [TW-1:0]         st_tag;
  logic [3:0]            st_error;
  logic                  st_valid;
  logic [PORTS-1:0]      m_status_valid;
  logic [3:0]            m_status_error;
  logic [SW-1:0]         m_status_seq;
  logic [PORTS*4-1:0]    outstanding;
  logic                  err_unexpected;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  recon_dma_rd_arbiter #(
    .PORTS(PORTS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .SEQ_W(SW), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(1048576)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .s_req_addr                    (s_req_addr),
    .s_req_len                     (s_req_len),
    .s_req_valid                   (s_req_valid),
    .s_req_ready                   (s_req_ready),
    .m_axis_read_desc_addr         (desc_addr),
    .m_axis_read_desc_len          (desc_len),
    .m_axis_read_desc_tag          (desc_tag),
    .m_axis_read_desc_valid        (desc_valid),
    .m_axis_read_desc_ready        (desc_ready),
    .s_axis_read_desc_status_tag   (st_tag),
    .s_axis_read_desc_status_error (st_error),
    .s_axis_read_desc_status_valid (st_valid),
    .m_status_valid                (m_status_valid),
    .m_status_error                (m_status_error),
    .m_status_seq                  (m_status_seq),
    .outstanding                   (outstanding),
    .err_unexpected                (err_unexpected)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
    s_req_addr[p*AW +: AW] = a;
    s_req_len[p*LW +: LW]  = l;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    s_req_valid = '0;
    desc_ready  = 1'b1;
    st_valid    = 1'b0;
    st_tag      = '0;
    st_error    = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [3:0] outs_p;
  logic [7:0] exp_tag;
  int         gp;

  initial begin
    s_req_addr = '0;
    s_req_len  = '0;
    do_reset();
    check("rst_ready", 64'(s_req_ready), 64'h0);
    check("rst_dvalid", 64'(desc_valid), 64'h0);
    check("rst_outst", 64'(outstanding), 64'h0);
    check("rst_unexp", 64'(err_unexpected), 64'h0);
    check("rst_svalid", 64'(m_status_valid), 64'h0);

    // Single request on port 1
    set_req(1, 34'h1_0000_0000, 20'd4096);
    s_req_valid = 4'b0010;
    #1;
    check("t1_ready", 64'(s_req_ready), 64'h2);
    tick();
    s_req_valid = '0;
    #1;
    check("t1_dvalid", 64'(desc_valid), 64'h1);
    check("t1_addr", 64'(desc_addr), 64'h1_0000_0000);
    check("t1_len", 64'(desc_len), 64'd4096);
    check("t1_tag", 64'(desc_tag), 64'h10);
    outs_p = outstanding[7:4];
    check("t1_outst1", 64'(outs_p), 64'h1);
    check("t1_ready_issue", 64'(s_req_ready), 64'h0);
    tick();
    check("t1_ddrop", 64'(desc_valid), 64'h0);
    st_tag   = 8'h10;
    st_error = 4'h3;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
    outs_p = outstanding[7:4];
    check("t1_outst1_done", 64'(outs_p), 64'h0);
    check("t1_spulse", 64'(m_status_valid), 64'h2);
    check("t1_serr", 64'(m_status_error), 64'h3);
    check("t1_sseq", 64'(m_status_seq), 64'h0);
    tick();
    check("t1_spulse_end", 64'(m_status_valid), 64'h0);

    // All ports requesting, immediate completions: order 0,1,2,3,0
    do_reset();
    for (int p = 0; p < PORTS; p++) set_req(p, 34'(p * 32'h100), 20'(p + 1));
    s_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gp      = k % 4;
      exp_tag = 8'((gp << 4) | (k / 4));
      #1;
      check("t2_ready", 64'(s_req_ready), 64'(1 << gp));
      tick();
      check("t2_dvalid", 64'(desc_valid), 64'h1);
      check("t2_tag", 64'(desc_tag), 64'(exp_tag));
      st_tag   = exp_tag;
      st_error = 4'h0;
      st_valid = 1'b1;
      tick();
      st_valid = 1'b0;
      check("t2_ddrop", 64'(desc_valid), 64'h0);
      check("t2_spulse", 64'(m_status_valid), 64'(1 << gp));
    end
    s_req_valid = '0;

    // Port 2 at its limit is skipped, then regranted after a completion
    do_reset();
    s_req_valid = 4'b0100;
    #1;
    check("t3_ready_a", 64'(s_req_ready), 64'h4);
    tick();
    check("t3_tag_a", 64'(desc_tag), 64'h20);
    tick();
    check("t3_ready_b", 64'(s_req_ready), 64'h4);
    tick();
    check("t3_tag_b", 64'(desc_tag), 64'h21);
    tick();
    outs_p = outstanding[11:8];
    check("t3_outst2", 64'(outs_p), 64'h2);
    s_req_valid = 4'b1101;
    #1;
    check("t3_ready_p3", 64'(s_req_ready), 64'h8);
    tick();
    check("t3_tag_p3", 64'(desc_tag), 64'h30);
    tick();
    check("t3_ready_p0", 64'(s_req_ready), 64'h1);
    tick();
    check("t3_tag_p0", 64'(desc_tag), 64'h00);
    tick();
    check("t3_ready_skip", 64'(s_req_ready), 64'h8);
    tick();
    check("t3_tag_p3b", 64'(desc_tag), 64'h31);
    st_tag   = 8'h20;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
    outs_p = outstanding[11:8];
    check("t3_outst2_dec", 64'(outs_p), 64'h1);
    check("t3_spulse", 64'(m_status_valid), 64'h4);
    s_req_valid = 4'b0100;
    #1;
    check("t3_ready_p2", 64'(s_req_ready), 64'h4);
    tick();
    check("t3_tag_p2", 64'(desc_tag), 64'h22);
    s_req_valid = '0;
    tick();

    // Backpressure: descriptor held for 10 cycles with ready low
    do_reset();
    desc_ready = 1'b0;
    set_req(0, 34'h2_ABCD_1234, 20'h00123);
    s_req_valid = 4'b0001;
    #1;
    check("t4_ready", 64'(s_req_ready), 64'h1);
    tick();
    s_req_valid = 4'b1111;
    set_req(0, 34'h3_0000_0000, 20'h00456);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", 64'(desc_valid), 64'h1);
      check("t4_hold_addr", 64'(desc_addr), 64'h2_ABCD_1234);
      check("t4_hold_len", 64'(desc_len), 64'h00123);
      check("t4_hold_tag", 64'(desc_tag), 64'h00);
      check("t4_hold_ready", 64'(s_req_ready), 64'h0);
      tick();
    end
    s_req_valid = '0;
    desc_ready  = 1'b1;
    tick();
    check("t4_ddrop", 64'(desc_valid), 64'h0);

    // Unexpected status, then grant and completion on port 0 together
    st_tag   = 8'h30;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
    check("t5_unexp", 64'(err_unexpected), 64'h1);
    check("t5_no_pulse", 64'(m_status_valid), 64'h0);
    s_req_valid = 4'b0001;
    st_tag      = 8'h00;
    st_valid    = 1'b1;
    #1;
    check("t5_ready", 64'(s_req_ready), 64'h1);
    tick();
    st_valid    = 1'b0;
    s_req_valid = '0;
    outs_p = outstanding[3:0];
    check("t5_outst0_same", 64'(outs_p), 64'h1);
    check("t5_spulse", 64'(m_status_valid), 64'h1);
    check("t5_tag", 64'(desc_tag), 64'h01);
    check("t5_unexp_sticky", 64'(err_unexpected), 64'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recon_dma_rd_arbiter.md
Name: recon_dma_rd_arbiter

Overview:
Shares one DMA read-descriptor channel between PORTS independent requesters, e.g. the reconfiguration controller's bitstream fetch, an ICAP readback engine and a host-driven loader. Round-robin arbitration grants one request at a time and registers it onto the descriptor channel. Each issued descriptor carries a tag that encodes the requester's index. Completion status returned by the DMA engine is decoded by tag, routed back to the owning requester, and used to enforce a per-requester limit on outstanding reads.

Parameters:
PORTS, 4, number of requesters (2..8)
ADDR_WIDTH, 34, DMA address width
LEN_WIDTH, 20, DMA length width
TAG_WIDTH, 8, DMA tag width; must be >= PORT_W+SEQ_W
PORT_W, $clog2(PORTS), tag field holding the port index (localparam)
SEQ_W, 4, per-port sequence field in the tag
MAX_OUTSTANDING, 2, maximum in-flight descriptors per port (1..15)
TIMEOUT_CYCLES, 1048576, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_req_addr  in  PORTS*ADDR_WIDTH  per-port read address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
s_req_len  in  PORTS*LEN_WIDTH  per-port read length in bytes
s_req_valid  in  PORTS  request valid
s_req_ready  out  PORTS  request accepted (one-hot or zero)
m_axis_read_desc_addr  out  ADDR_WIDTH  descriptor address
m_axis_read_desc_len  out  LEN_WIDTH  descriptor length
m_axis_read_desc_tag  out  TAG_WIDTH  {zero pad, port index, sequence}
m_axis_read_desc_valid  out  1  descriptor valid
m_axis_read_desc_ready  in  1  DMA accepts descriptor
s_axis_read_desc_status_tag  in  TAG_WIDTH  completion tag
s_axis_read_desc_status_error  in  4  completion error code
s_axis_read_desc_status_valid  in  1  completion strobe
m_status_valid  out  PORTS  per-port completion pulse
m_status_error  out  4  error code for the current pulse
m_status_seq  out  SEQ_W  sequence number of the completed descriptor
outstanding  out  PORTS*4  per-port in-flight count
err_unexpected  out  1  sticky: a status arrived for a port with zero outstanding

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = PORTS-1, all sequence counters and outstanding counts 0.
- A port is eligible when s_req_valid[p] is high and outstanding[p] < MAX_OUTSTANDING.
- State IDLE:
  - If any port is eligible, grant the first eligible port searching upward from last_grant+1, wrapping modulo PORTS.
  - s_req_ready[g] is asserted combinationally in that cycle.
  - On the next edge: register addr, len and tag = {g, seq[g]} onto the descriptor outputs; set valid=1; set last_grant=g; increment seq[g] (wraps at 2^SEQ_W); increment outstanding[g]; go to ISSUE.
- State ISSUE:
  - Descriptor fields and valid are held stable while ready=0.
  - When valid && ready, valid drops on the next edge and the state returns to IDLE.
  - s_req_ready is 0 throughout ISSUE.
- Throughput: at most one descriptor per 2 cycles. Latency from request acceptance to valid is 1 cycle.
- Status path:
  - On status_valid, decode p = tag[PORT_W+SEQ_W-1 : SEQ_W].
  - If outstanding[p] > 0: decrement it, and one cycle later pulse m_status_valid[p] for 1 cycle with m_status_error and m_status_seq.
  - Otherwise: set err_unexpected, no pulse.
  - A decoded p >= PORTS is treated as unexpected.
- Simultaneous grant and status on the same port: the count is unchanged (+1 -1).
- Status may arrive while in ISSUE; it is processed regardless of arbiter state.
- Reset mid-ISSUE: the descriptor is dropped, counts are cleared, and late statuses set err_unexpected.
- A port whose count equals MAX_OUTSTANDING is skipped by the arbiter. Its request is neither acknowledged nor blocking other ports.

Optional Feature:
RECON_DMA_ARB_TIMEOUT_EN.
- Defined:
  - Adds a per-port watchdog counter that increments while outstanding[p] > 0 and resets on any status for p.
  - On reaching TIMEOUT_CYCLES: set sticky output timeout_err[PORTS], force outstanding[p] to 0, and pulse m_status_valid[p] with m_status_error = 4'hF.
  - Sticky bits are cleared only by rst.
- Undefined:
  - No counters and no timeout_err port; in-flight reads may hang indefinitely.

Decomposition:
- Package recon_dma_pkg holds the tag field widths, the ERR_TIMEOUT = 4'hF code, the state encoding (IDLE=0, ISSUE=1), and a helper function that packs and unpacks tags.
- Sub-module rr_arbiter (PORTS-wide, with a last_grant input, one-hot grant output and a grant_valid output) is a natural split and is reusable for a future write-channel arbiter.

Test Plan:
- Single request, port 1, addr 0x1_0000_0000, len 4096, ready=1 → desc valid 1 cycle after acceptance, tag 0x10, outstanding[1]=1; status tag 0x10 → m_status_valid=4'b0010, outstanding[1]=0.
- All 4 ports valid continuously, ready=1, statuses returned immediately → grant order 0,1,2,3,0, with one descriptor every 2 cycles.
- Port 2 issues 2 descriptors with no status → port 2 is skipped while ports 0/3 are served; after a status for tag 0x20, port 2 is granted with tag 0x22.
- ready held 0 for 10 cycles → addr, len and tag are stable, and s_req_ready stays 0 for all ports.
- Status tag 0x30 with outstanding[3]=0 → err_unexpected=1, no pulse; a grant and a status on port 0 in the same cycle → outstanding[0] unchanged.
- With RECON_DMA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64 → 64 cycles without status gives timeout_err[0]=1, an error pulse with code 0xF, and outstanding[0]=0.
